// File: rtl/monitor_contador_pkg.sv
// Shared types and constants for the counter monitor and its transition classifier.
package contador_pkg;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_WRAP_W = 8;

  localparam logic [DEF_WIDTH-1:0] CNT_MAX = {DEF_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_e;

  // One-hot classification of a (prev, sample) pair.
  typedef struct packed {
    logic step;
    logic wrap;
    logic restart;
    logic jump;
  } trans_t;

endpackage

// File: rtl/monitor_contador_if.sv
// Bus bundle between the monitored counter stage and the monitor.
interface monitor_contador_if #(
  parameter int unsigned WIDTH  = contador_pkg::DEF_WIDTH,
  parameter int unsigned WRAP_W = contador_pkg::DEF_WRAP_W
);
  logic [WIDTH-1:0]  count_in;
  logic [WIDTH-1:0]  match_val;
  logic              clear;
  logic              wrap_pulse;
  logic              match_pulse;
  logic              restart_pulse;
  logic              jump_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic              error_sticky;
  logic [1:0]        state;

  modport master (
    output count_in, match_val, clear,
    input  wrap_pulse, match_pulse, restart_pulse, jump_pulse,
    input  wrap_count, error_sticky, state
  );

  modport slave (
    input  count_in, match_val, clear,
    output wrap_pulse, match_pulse, restart_pulse, jump_pulse,
    output wrap_count, error_sticky, state
  );
endinterface

// File: rtl/monitor_contador_clasificador_transicion.sv
// Combinational classifier: previous sample p and new sample s -> step/wrap/restart/jump.
module clasificador_transicion
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0] p_i,
  output trans_t           trans_c
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  // Priority order matters: a max->0 transition is a wrap, never a restart.
  always_comb begin
    trans_c = '0;
    if ((p_i != MAX) && (s_i == WIDTH'(p_i + WIDTH'(1)))) begin
      trans_c.step = 1'b1;
    end else if ((p_i == MAX) && (s_i == '0)) begin
      trans_c.wrap = 1'b1;
    end else if (s_i == '0) begin
      trans_c.restart = 1'b1;
    end else begin
      trans_c.jump = 1'b1;
    end
  end

endmodule

// File: rtl/monitor_contador.sv
// Checks that an upstream counter advances by +1 mod 2^WIDTH and emits event pulses.
module monitor_contador
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned WRAP_W = DEF_WRAP_W
) (
  input logic              clk,
  input logic              reset,
  monitor_contador_if.slave mon
);

  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

  state_e            state_q,         state_d;
  logic [WIDTH-1:0]  prev_q,          prev_d;
  logic              wrap_pulse_q,    wrap_pulse_d;
  logic              match_pulse_q,   match_pulse_d;
  logic              restart_pulse_q, restart_pulse_d;
  logic              jump_pulse_q,    jump_pulse_d;
  logic [WRAP_W-1:0] wrap_count_q,    wrap_count_d;
  logic              error_sticky_q,  error_sticky_d;

  trans_t trans;

  clasificador_transicion #(.WIDTH(WIDTH)) u_clasificador (
    .s_i     (mon.count_in),
    .p_i     (prev_q),
    .trans_c (trans)
  );

  always_comb begin
    state_d         = state_q;
    prev_d          = mon.count_in;
    wrap_pulse_d    = 1'b0;
    match_pulse_d   = 1'b0;
    restart_pulse_d = 1'b0;
    jump_pulse_d    = 1'b0;
    wrap_count_d    = wrap_count_q;
    error_sticky_d  = error_sticky_q;

    if (mon.clear) begin
      // Clear wins over whatever the sample would have been classified as.
      wrap_count_d   = '0;
      error_sticky_d = 1'b0;
      state_d        = SYNC;
    end else begin
      unique case (state_q)
        SYNC: state_d = TRACK;
        TRACK: begin
          match_pulse_d = (trans.step | trans.wrap | trans.restart)
                        & (mon.count_in == mon.match_val);
          if (trans.wrap) begin
            wrap_pulse_d = 1'b1;
            wrap_count_d = (wrap_count_q == WRAP_MAX) ? wrap_count_q
                                                      : wrap_count_q + WRAP_W'(1);
          end
          // Holding at 0 is legal (upstream held in reset) but only pulses on entry.
          if (trans.restart) begin
            restart_pulse_d = (prev_q != '0);
            wrap_count_d    = '0;
          end
          if (trans.jump) begin
            jump_pulse_d   = 1'b1;
            error_sticky_d = 1'b1;
            state_d        = ERROR;
          end
        end
        ERROR: state_d = ERROR;
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= SYNC;
      prev_q          <= '0;
      wrap_pulse_q    <= 1'b0;
      match_pulse_q   <= 1'b0;
      restart_pulse_q <= 1'b0;
      jump_pulse_q    <= 1'b0;
      wrap_count_q    <= '0;
      error_sticky_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      prev_q          <= prev_d;
      wrap_pulse_q    <= wrap_pulse_d;
      match_pulse_q   <= match_pulse_d;
      restart_pulse_q <= restart_pulse_d;
      jump_pulse_q    <= jump_pulse_d;
      wrap_count_q    <= wrap_count_d;
      error_sticky_q  <= error_sticky_d;
    end
  end

  assign mon.wrap_pulse    = wrap_pulse_q;
  assign mon.match_pulse   = match_pulse_q;
  assign mon.restart_pulse = restart_pulse_q;
  assign mon.jump_pulse    = jump_pulse_q;
  assign mon.wrap_count    = wrap_count_q;
  assign mon.error_sticky  = error_sticky_q;
  assign mon.state         = state_q;

endmodule

// File: tb/tb_monitor_contador.sv
// Directed plus random stimulus for monitor_contador against an integer reference model.
module tb_monitor_contador;

  localparam int LAP  = 16;
  localparam int WMAX = 255;

  logic clk;
  logic reset;
  monitor_contador_if mon_if ();

  monitor_contador dut (
    .clk   (clk),
    .reset (reset),
    .mon   (mon_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: mode 0=sync, 1=track, 2=error.
  int m_mode, m_prev, mv;
  int e_wrap, e_match, e_restart, e_jump, e_wc, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wrap_pulse"},    32'(mon_if.wrap_pulse),    32'(e_wrap));
    chk({tag, ".match_pulse"},   32'(mon_if.match_pulse),   32'(e_match));
    chk({tag, ".restart_pulse"}, 32'(mon_if.restart_pulse), 32'(e_restart));
    chk({tag, ".jump_pulse"},    32'(mon_if.jump_pulse),    32'(e_jump));
    chk({tag, ".wrap_count"},    32'(mon_if.wrap_count),    32'(e_wc));
    chk({tag, ".error_sticky"},  32'(mon_if.error_sticky),  32'(e_err));
    chk({tag, ".state"},         32'(mon_if.state),         32'(m_mode));
  endtask

  task automatic model_reset();
    m_mode = 0; m_prev = 0;
    e_wrap = 0; e_match = 0; e_restart = 0; e_jump = 0; e_wc = 0; e_err = 0;
  endtask

  task automatic model_edge(input int s, input bit clr);
    e_wrap = 0; e_match = 0; e_restart = 0; e_jump = 0;
    if (clr) begin
      e_wc = 0; e_err = 0; m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_prev == LAP - 1 && s == 0) begin
        e_wrap = 1;
        e_wc   = (e_wc < WMAX) ? e_wc + 1 : WMAX;
      end else if (s == (m_prev + 1) % LAP) begin
        // ordinary +1 advance
      end else if (s == 0) begin
        e_restart = (m_prev != 0);
        e_wc      = 0;
      end else begin
        e_jump = 1; e_err = 1; m_mode = 2;
      end
      if (!e_jump) e_match = (s == mv);
    end
    m_prev = s;
  endtask

  task automatic drive(input string tag, input int s, input bit clr);
    mon_if.count_in = 4'(s);
    mon_if.clear    = clr;
    model_edge(s, clr);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_mv(input int v);
    mv = v;
    mon_if.match_val = 4'(v);
  endtask

  initial begin
    int s, r;
    bit clr;
    reset = 1'b0;
    mon_if.count_in = '0;
    mon_if.clear    = 1'b0;
    set_mv(5);
    model_reset();

    #1 reset = 1'b1;
    #1 check_all("reset");
    #6 reset = 1'b0;

    // One full lap plus a wrap, with match_val=5.
    for (int v = 0; v < LAP; v++) drive("lap0", v, 1'b0);
    drive("wrap0", 0, 1'b0);
    drive("lap0_tail", 1, 1'b0);
    chk("lap0.wrap_count_is_1", 32'(mon_if.wrap_count), 32'd1);
    chk("lap0.state_track",     32'(mon_if.state),      32'd1);

    // Two more laps, ending at 3,4.
    for (int v = 2; v < LAP; v++) drive("laps", v, 1'b0);
    for (int v = 0; v < LAP; v++) drive("laps", v, 1'b0);
    for (int v = 0; v < 5; v++)   drive("laps", v, 1'b0);
    chk("laps.wrap_count_is_3", 32'(mon_if.wrap_count), 32'd3);

    // Upstream restart: 3,4,0,0,0,1.
    drive("restart0", 0, 1'b0);
    chk("restart.pulse_once", 32'(mon_if.restart_pulse), 32'd1);
    drive("restart_hold", 0, 1'b0);
    chk("restart.hold_no_pulse", 32'(mon_if.restart_pulse), 32'd0);
    drive("restart_hold", 0, 1'b0);
    drive("restart_up", 1, 1'b0);
    chk("restart.wrap_count_0", 32'(mon_if.wrap_count), 32'd0);

    // One wrap, then 6,7,9 jump; wraps in ERROR must not count.
    for (int v = 2; v < LAP; v++) drive("pre_jump", v, 1'b0);
    drive("pre_jump_wrap", 0, 1'b0);
    for (int v = 1; v < 8; v++) drive("pre_jump", v, 1'b0);
    drive("jump", 9, 1'b0);
    chk("jump.pulse",  32'(mon_if.jump_pulse),   32'd1);
    chk("jump.sticky", 32'(mon_if.error_sticky), 32'd1);
    chk("jump.state",  32'(mon_if.state),        32'd2);
    for (int v = 10; v < LAP; v++) drive("in_error", v, 1'b0);
    for (int v = 0; v < LAP; v++)  drive("in_error", v, 1'b0);
    chk("error.wrap_frozen", 32'(mon_if.wrap_count), 32'd1);

    // Clear on the same edge as a 15->0 wrap.
    drive("clear_on_wrap", 0, 1'b1);
    chk("clear.state_sync",  32'(mon_if.state),      32'd0);
    chk("clear.no_wrap",     32'(mon_if.wrap_pulse), 32'd0);
    drive("after_clear", 1, 1'b0);
    chk("clear.state_track", 32'(mon_if.state),      32'd1);

    // 300 wraps: saturation at 255.
    for (int v = 2; v < LAP; v++) drive("sat", v, 1'b0);
    for (int lap = 0; lap < 300; lap++)
      for (int v = 0; v < LAP; v++) drive("sat", v, 1'b0);
    chk("sat.wrap_count_255", 32'(mon_if.wrap_count), 32'd255);

    // Async reset mid-lap, checked before any clock edge.
    for (int v = 0; v < 8; v++) drive("mid_lap", v, 1'b0);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all("async_reset");
    chk("async_reset.wrap_count_0", 32'(mon_if.wrap_count), 32'd0);
    #1 reset = 1'b0;

    // Random traffic: mostly legal steps, with restarts, holds, jumps, clears.
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 72)      s = (m_prev + 1) % LAP;
      else if (r < 82) s = 0;
      else if (r < 88) s = m_prev;
      else             s = int'($urandom_range(0, LAP - 1));
      clr = (m_mode == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) set_mv(int'($urandom_range(0, LAP - 1)));
      drive("random", s, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
